// File: rtl/safe_wrapper_launcher_pkg.sv
// Shared types and status codes for the safe-wrapper launch initiator.
package safe_wrapper_launcher_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    DRAIN,
    RESP
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  typedef struct packed {
    logic [2:0]  master_core;
    logic        safe_mode;
    logic [1:0]  safe_cfg;
    logic        critical;
    logic [31:0] boot_addr;
  } launch_cfg_t;

endpackage

// File: rtl/safe_wrapper_launcher.sv
// Host-side launcher: drives wrapper config, pulses a start window, waits for
// end-of-routine / timeout / abort and returns a completion record.
module safe_wrapper_launcher
  import safe_wrapper_launcher_pkg::*;
#(
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_master_core_i,
  input  logic             cmd_safe_mode_i,
  input  logic [1:0]       cmd_safe_cfg_i,
  input  logic             cmd_critical_i,
  input  logic [31:0]      cmd_boot_addr_i,
  input  logic [CNT_W-1:0] cmd_timeout_i,
  input  logic             abort_i,
  output logic [2:0]       master_core_o,
  output logic             safe_mode_o,
  output logic [1:0]       safe_configuration_o,
  output logic             critical_section_o,
  output logic [31:0]      boot_addr_o,
  output logic             start_o,
  input  logic             end_sw_routine_i,
  output logic             done_valid_o,
  input  logic             done_ready_i,
  output logic [1:0]       done_status_o,
  output logic [CNT_W-1:0] done_cycles_o
);

  localparam int unsigned SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  state_t            state_q, state_d;
  launch_cfg_t       cfg_q, cfg_d;
  logic [CNT_W-1:0]  timeout_q, timeout_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [SW-1:0]     setup_cnt_q, setup_cnt_d;
  logic [1:0]        status_q, status_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic              start_q;
  logic              done_valid_q;

  assign cnt_inc = (run_cnt_q == '1) ? '1 : run_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    timeout_d   = timeout_q;
    run_cnt_d   = run_cnt_q;
    setup_cnt_d = setup_cnt_q;
    status_d    = status_q;
    cycles_d    = cycles_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          cfg_d.master_core = cmd_master_core_i;
          cfg_d.safe_mode   = cmd_safe_mode_i;
          cfg_d.safe_cfg    = cmd_safe_cfg_i;
          cfg_d.critical    = cmd_critical_i;
          cfg_d.boot_addr   = cmd_boot_addr_i;
          timeout_d         = cmd_timeout_i;
          run_cnt_d         = '0;
          setup_cnt_d       = SW'(SETUP_CYCLES - 1);
          state_d           = SETUP;
        end
      end
      SETUP: begin
        if (abort_i) begin
          status_d = ST_ABORT;
          cycles_d = '0;
          state_d  = DRAIN;
        end else if (setup_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          setup_cnt_d = setup_cnt_q - SW'(1);
        end
      end
      RUN: begin
        run_cnt_d = cnt_inc;
        // Exit priority: end-of-routine beats timeout beats abort.
        if (end_sw_routine_i && (run_cnt_q >= CNT_W'(BLANK_CYCLES))) begin
          status_d = ST_OK;
          cycles_d = cnt_inc;
          state_d  = DRAIN;
        end else if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
          status_d = ST_TIMEOUT;
          cycles_d = cnt_inc;
          state_d  = DRAIN;
        end else if (abort_i) begin
          status_d = ST_ABORT;
          cycles_d = cnt_inc;
          state_d  = DRAIN;
        end
      end
      DRAIN: state_d = RESP;
      RESP: begin
        if (done_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      timeout_q    <= '0;
      run_cnt_q    <= '0;
      setup_cnt_q  <= '0;
      status_q     <= ST_OK;
      cycles_q     <= '0;
      start_q      <= 1'b0;
      done_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      timeout_q    <= timeout_d;
      run_cnt_q    <= run_cnt_d;
      setup_cnt_q  <= setup_cnt_d;
      status_q     <= status_d;
      cycles_q     <= cycles_d;
      // Registered from next state so start/valid align exactly with RUN/RESP.
      start_q      <= (state_d == RUN);
      done_valid_q <= (state_d == RESP);
    end
  end

  assign cmd_ready_o          = (state_q == IDLE);
  assign master_core_o        = cfg_q.master_core;
  assign safe_mode_o          = cfg_q.safe_mode;
  assign safe_configuration_o = cfg_q.safe_cfg;
  assign critical_section_o   = cfg_q.critical;
  assign boot_addr_o          = cfg_q.boot_addr;
  assign start_o              = start_q;
  assign done_valid_o         = done_valid_q;
  assign done_status_o        = status_q;
  assign done_cycles_o        = cycles_q;

endmodule

// File: tb/tb_safe_wrapper_launcher.sv
// Directed self-checking bench for safe_wrapper_launcher.
module tb_safe_wrapper_launcher;

  localparam int unsigned CNT_W = 24;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             cmd_valid_i = 1'b0;
  logic             cmd_ready_o;
  logic [2:0]       cmd_master_core_i = '0;
  logic             cmd_safe_mode_i = 1'b0;
  logic [1:0]       cmd_safe_cfg_i = '0;
  logic             cmd_critical_i = 1'b0;
  logic [31:0]      cmd_boot_addr_i = '0;
  logic [CNT_W-1:0] cmd_timeout_i = '0;
  logic             abort_i = 1'b0;
  logic [2:0]       master_core_o;
  logic             safe_mode_o;
  logic [1:0]       safe_configuration_o;
  logic             critical_section_o;
  logic [31:0]      boot_addr_o;
  logic             start_o;
  logic             end_sw_routine_i = 1'b0;
  logic             done_valid_o;
  logic             done_ready_i = 1'b0;
  logic [1:0]       done_status_o;
  logic [CNT_W-1:0] done_cycles_o;

  int n_checks = 0;
  int n_pass   = 0;

  safe_wrapper_launcher #(
    .CNT_W       (CNT_W),
    .SETUP_CYCLES(2),
    .BLANK_CYCLES(2)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .cmd_valid_i         (cmd_valid_i),
    .cmd_ready_o         (cmd_ready_o),
    .cmd_master_core_i   (cmd_master_core_i),
    .cmd_safe_mode_i     (cmd_safe_mode_i),
    .cmd_safe_cfg_i      (cmd_safe_cfg_i),
    .cmd_critical_i      (cmd_critical_i),
    .cmd_boot_addr_i     (cmd_boot_addr_i),
    .cmd_timeout_i       (cmd_timeout_i),
    .abort_i             (abort_i),
    .master_core_o       (master_core_o),
    .safe_mode_o         (safe_mode_o),
    .safe_configuration_o(safe_configuration_o),
    .critical_section_o  (critical_section_o),
    .boot_addr_o         (boot_addr_o),
    .start_o             (start_o),
    .end_sw_routine_i    (end_sw_routine_i),
    .done_valid_o        (done_valid_o),
    .done_ready_i        (done_ready_i),
    .done_status_o       (done_status_o),
    .done_cycles_o       (done_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // Presents a command at the current negedge; returns at the negedge of cycle 1.
  task automatic send_cmd(input logic [2:0] core, input logic sm, input logic [1:0] cfg,
                          input logic crit, input logic [31:0] addr,
                          input logic [CNT_W-1:0] to);
    cmd_master_core_i = core;
    cmd_safe_mode_i   = sm;
    cmd_safe_cfg_i    = cfg;
    cmd_critical_i    = crit;
    cmd_boot_addr_i   = addr;
    cmd_timeout_i     = to;
    cmd_valid_i       = 1'b1;
    @(negedge clk_i);
    cmd_valid_i       = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int hi, output bit got);
    hi  = 0;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk_i);
      if (start_o) hi++;
      if (done_valid_o) got = 1'b1;
    end
  endtask

  task automatic finish_resp();
    done_ready_i = 1'b1;
    @(negedge clk_i);
    done_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (start_o !== 1'b0 || done_valid_o !== 1'b0) $display("FAIL reset_ctrl start=%b done_valid=%b exp 0/0", start_o, done_valid_o);
    else n_pass++;
    n_checks++;
    if ({master_core_o, safe_mode_o, safe_configuration_o, critical_section_o} !== 7'd0 || boot_addr_o !== 32'd0)
      $display("FAIL reset_cfg core=%b sm=%b cfg=%b crit=%b addr=%h exp all 0", master_core_o, safe_mode_o, safe_configuration_o, critical_section_o, boot_addr_o);
    else n_pass++;
    n_checks++;
    if (done_status_o !== 2'b00 || done_cycles_o !== '0) $display("FAIL reset_done status=%b cycles=%0d exp 0/0", done_status_o, done_cycles_o);
    else n_pass++;
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (cmd_ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", cmd_ready_o);
    else n_pass++;
  endtask

  task automatic test_nominal();
    int bad = 0;
    send_cmd(3'b010, 1'b1, 2'b01, 1'b0, 32'h0000_0180, '0);
    n_checks++;
    if (master_core_o !== 3'b010 || safe_mode_o !== 1'b1 || safe_configuration_o !== 2'b01 ||
        critical_section_o !== 1'b0 || boot_addr_o !== 32'h0000_0180)
      $display("FAIL nom_cfg core=%b sm=%b cfg=%b crit=%b addr=%h exp 010/1/01/0/00000180", master_core_o, safe_mode_o, safe_configuration_o, critical_section_o, boot_addr_o);
    else n_pass++;
    n_checks++;
    if (start_o !== 1'b0 || cmd_ready_o !== 1'b0) $display("FAIL nom_c1 start=%b ready=%b exp 0/0", start_o, cmd_ready_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (start_o !== 1'b0) $display("FAIL nom_c2_start got %b exp 0", start_o);
    else n_pass++;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk_i);
      if (start_o !== 1'b1) bad++;
      if (k == 10) end_sw_routine_i = 1'b1;
    end
    n_checks++;
    if (bad != 0) $display("FAIL nom_run_start low_cycles=%0d exp 0", bad);
    else n_pass++;
    @(negedge clk_i);
    end_sw_routine_i = 1'b0;
    n_checks++;
    if (start_o !== 1'b0 || done_valid_o !== 1'b0) $display("FAIL nom_drain start=%b valid=%b exp 0/0", start_o, done_valid_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++;
    if (done_valid_o !== 1'b1 || done_status_o !== 2'b00 || done_cycles_o !== 24'd11)
      $display("FAIL nom_resp valid=%b status=%b cycles=%0d exp 1/00/11", done_valid_o, done_status_o, done_cycles_o);
    else n_pass++;
    finish_resp();
    n_checks++;
    if (done_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || boot_addr_o !== 32'h0000_0180)
      $display("FAIL nom_idle valid=%b ready=%b addr=%h exp 0/1/00000180", done_valid_o, cmd_ready_o, boot_addr_o);
    else n_pass++;
  endtask

  task automatic test_stale_end();
    int bad = 0;
    end_sw_routine_i = 1'b1;
    send_cmd(3'b001, 1'b0, 2'b10, 1'b1, 32'h0000_2000, '0);
    @(negedge clk_i);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk_i);
      if (start_o !== 1'b1) bad++;
      if (k == 1) end_sw_routine_i = 1'b0;
      if (k == 20) end_sw_routine_i = 1'b1;
    end
    n_checks++;
    if (bad != 0) $display("FAIL stale_early_exit low_cycles=%0d exp 0", bad);
    else n_pass++;
    @(negedge clk_i);
    end_sw_routine_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (done_valid_o !== 1'b1 || done_status_o !== 2'b00 || done_cycles_o !== 24'd21)
      $display("FAIL stale_resp valid=%b status=%b cycles=%0d exp 1/00/21", done_valid_o, done_status_o, done_cycles_o);
    else n_pass++;
    finish_resp();
  endtask

  task automatic test_timeout();
    int hi;
    bit got;
    send_cmd(3'b011, 1'b0, 2'b00, 1'b0, 32'h0000_0040, 24'd5);
    run_until_done(100, hi, got);
    n_checks++;
    if (!got || hi != 5) $display("FAIL timeout_start got_done=%0d start_cycles=%0d exp 1/5", got, hi);
    else n_pass++;
    n_checks++;
    if (done_status_o !== 2'b01 || done_cycles_o !== 24'd5) $display("FAIL timeout_resp status=%b cycles=%0d exp 01/5", done_status_o, done_cycles_o);
    else n_pass++;
    finish_resp();
  endtask

  task automatic test_simultaneous();
    send_cmd(3'b100, 1'b1, 2'b11, 1'b1, 32'h0000_0800, 24'd8);
    @(negedge clk_i);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk_i);
      if (k == 7) begin
        end_sw_routine_i = 1'b1;
        abort_i          = 1'b1;
      end
    end
    @(negedge clk_i);
    end_sw_routine_i = 1'b0;
    abort_i          = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (done_valid_o !== 1'b1 || done_status_o !== 2'b00 || done_cycles_o !== 24'd8)
      $display("FAIL simul_resp valid=%b status=%b cycles=%0d exp 1/00/8", done_valid_o, done_status_o, done_cycles_o);
    else n_pass++;
    finish_resp();
  endtask

  task automatic test_abort_setup();
    int hi;
    bit got;
    send_cmd(3'b110, 1'b0, 2'b01, 1'b0, 32'h0000_1000, '0);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    if (start_o) hi = 1; else hi = 0;
    begin
      int hi2;
      run_until_done(20, hi2, got);
      hi += hi2;
    end
    n_checks++;
    if (!got || hi != 0) $display("FAIL abort_setup_start got_done=%0d start_cycles=%0d exp 1/0", got, hi);
    else n_pass++;
    n_checks++;
    if (done_status_o !== 2'b10 || done_cycles_o !== '0) $display("FAIL abort_setup_resp status=%b cycles=%0d exp 10/0", done_status_o, done_cycles_o);
    else n_pass++;
    finish_resp();
  endtask

  task automatic test_back_to_back();
    int hi;
    bit got;
    int bad_ready = 0, bad_rec = 0, bad_cfg = 0;
    send_cmd(3'b001, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 24'd3);
    run_until_done(50, hi, got);
    n_checks++;
    if (!got) $display("FAIL b2b_first_done got %0d exp 1", got);
    else n_pass++;
    cmd_master_core_i = 3'b101;
    cmd_safe_mode_i   = 1'b1;
    cmd_safe_cfg_i    = 2'b10;
    cmd_critical_i    = 1'b1;
    cmd_boot_addr_i   = 32'hDEAD_BEEF;
    cmd_timeout_i     = '0;
    cmd_valid_i       = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (cmd_ready_o !== 1'b0) bad_ready++;
      if (done_valid_o !== 1'b1 || done_status_o !== 2'b01 || done_cycles_o !== 24'd3) bad_rec++;
      if (master_core_o !== 3'b001 || boot_addr_o !== 32'h0000_0100) bad_cfg++;
    end
    n_checks++;
    if (bad_ready != 0) $display("FAIL bp_ready cycles_ready_high=%0d exp 0", bad_ready);
    else n_pass++;
    n_checks++;
    if (bad_rec != 0) $display("FAIL bp_record unstable_cycles=%0d exp 0", bad_rec);
    else n_pass++;
    n_checks++;
    if (bad_cfg != 0) $display("FAIL bp_cfg_overwritten cycles=%0d exp 0", bad_cfg);
    else n_pass++;
    finish_resp();
    n_checks++;
    if (done_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || master_core_o !== 3'b001)
      $display("FAIL b2b_idle valid=%b ready=%b core=%b exp 0/1/001", done_valid_o, cmd_ready_o, master_core_o);
    else n_pass++;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    n_checks++;
    if (master_core_o !== 3'b101 || boot_addr_o !== 32'hDEAD_BEEF || cmd_ready_o !== 1'b0)
      $display("FAIL b2b_second core=%b addr=%h ready=%b exp 101/deadbeef/0", master_core_o, boot_addr_o, cmd_ready_o);
    else n_pass++;
    repeat (4) @(negedge clk_i);
    n_checks++;
    if (start_o !== 1'b1) $display("FAIL b2b_run_start got %b exp 1", start_o);
    else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if (start_o !== 1'b0 || done_valid_o !== 1'b0 || cmd_ready_o !== 1'b1)
      $display("FAIL rst_async start=%b valid=%b ready=%b exp 0/0/1", start_o, done_valid_o, cmd_ready_o);
    else n_pass++;
    n_checks++;
    if ({master_core_o, safe_mode_o, safe_configuration_o, critical_section_o} !== 7'd0 ||
        boot_addr_o !== 32'd0 || done_status_o !== 2'b00 || done_cycles_o !== '0)
      $display("FAIL rst_async_cfg core=%b addr=%h status=%b cycles=%0d exp all 0", master_core_o, boot_addr_o, done_status_o, done_cycles_o);
    else n_pass++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if (start_o !== 1'b0 || done_valid_o !== 1'b0 || cmd_ready_o !== 1'b1)
      $display("FAIL rst_after start=%b valid=%b ready=%b exp 0/0/1", start_o, done_valid_o, cmd_ready_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stale_end();
    test_timeout();
    test_simultaneous();
    test_abort_setup();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
